// File: rtl/asip_pkg.sv
// Shared opcode, ALU-select and FSM-state definitions for the vector ALU sequencer.
// Helper functions map a raw opcode to its legality, ALU code and latency.
package asip_pkg;

    typedef enum logic [3:0] {
        OP_MUL = 4'b0000,
        OP_DIV = 4'b0001,
        OP_ADD = 4'b0100,
        OP_BEQ = 4'b1001
    } opcode_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_MUL = 2'b01;
    localparam logic [1:0] ALU_DIV = 2'b10;
    localparam logic [1:0] ALU_CMP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB,
        ST_DONE
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_MUL, OP_DIV, OP_ADD, OP_BEQ: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] op_alu_code(input logic [3:0] op);
        case (op)
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            OP_BEQ:  return ALU_CMP;
            default: return ALU_ADD;
        endcase
    endfunction

    // Execute cycles per lane; single-cycle ops and anything unknown report 1.
    function automatic int unsigned op_latency(input logic [3:0] op,
                                               input int unsigned mul_lat,
                                               input int unsigned div_lat);
        case (op)
            OP_MUL:  return mul_lat;
            OP_DIV:  return div_lat;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/op_latency_counter.sv
// Per-lane execute latency down-counter: load a start value, count down while
// enabled, and flag when the count has reached zero.
module op_latency_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/vec_alu_sequencer.sv
// Sequences one decoded vector ALU instruction across LANES lanes through a
// shared scalar ALU: per lane, lat execute cycles followed by one write-back cycle.
module vec_alu_sequencer
    import asip_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [3:0]               opcode,
    output logic                     issue_ready,
    input  logic                     flush,
    output logic [1:0]               alu_control,
    output logic                     alu_en,
    output logic [$clog2(LANES)-1:0] lane_idx,
    input  logic                     alu_zero,
    output logic                     lane_we,
    output logic                     stall,
    output logic                     done,
    output logic                     branch_taken,
    output logic                     illegal
);

    localparam int LANE_W  = $clog2(LANES);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);

    state_t            state_reg;
    logic [3:0]        op_reg;
    logic [LANE_W-1:0] lane_reg;
    logic              eq_reg;
    logic [1:0]        alu_control_reg;
    logic              alu_en_reg;
    logic              lane_we_reg;
    logic              done_reg;
    logic              branch_reg;
    logic              illegal_reg;

    logic              accept;
    logic              lane_last;
    logic [3:0]        lat_op;
    logic [CNT_W-1:0]  load_value;
    logic              cnt_load;
    logic              cnt_enable;
    logic              cnt_zero;

    assign accept     = issue_valid && (state_reg == ST_IDLE) && !flush;
    assign lane_last  = (lane_reg == LANE_W'(LANES - 1));
    // The counter is loaded either at acceptance (fresh opcode) or when moving to the next lane.
    assign lat_op     = (state_reg == ST_IDLE) ? opcode : op_reg;
    assign load_value = CNT_W'(op_latency(lat_op, int'(MUL_LAT), int'(DIV_LAT)) - 1);
    assign cnt_load   = (accept && op_legal(opcode)) ||
                        ((state_reg == ST_WB) && !flush && !lane_last);
    assign cnt_enable = (state_reg == ST_EXEC) && !flush;

    op_latency_counter #(
        .WIDTH(CNT_W)
    ) u_latency (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_value(load_value),
        .enable    (cnt_enable),
        .zero      (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            op_reg          <= 4'b0000;
            lane_reg        <= '0;
            eq_reg          <= 1'b0;
            alu_control_reg <= ALU_ADD;
            alu_en_reg      <= 1'b0;
            lane_we_reg     <= 1'b0;
            done_reg        <= 1'b0;
            branch_reg      <= 1'b0;
            illegal_reg     <= 1'b0;
        end else begin
            lane_we_reg <= 1'b0;
            done_reg    <= 1'b0;
            branch_reg  <= 1'b0;
            illegal_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (op_legal(opcode)) begin
                            state_reg       <= ST_EXEC;
                            op_reg          <= opcode;
                            lane_reg        <= '0;
                            eq_reg          <= 1'b1;
                            alu_control_reg <= op_alu_code(opcode);
                            alu_en_reg      <= 1'b1;
                        end else begin
                            illegal_reg <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (flush) begin
                        state_reg       <= ST_IDLE;
                        lane_reg        <= '0;
                        alu_control_reg <= ALU_ADD;
                        alu_en_reg      <= 1'b0;
                    end else if (cnt_zero) begin
                        state_reg   <= ST_WB;
                        lane_we_reg <= (op_reg != OP_BEQ);
                    end
                end
                ST_WB: begin
                    eq_reg <= eq_reg & alu_zero;
                    if (flush) begin
                        state_reg       <= ST_IDLE;
                        lane_reg        <= '0;
                        alu_control_reg <= ALU_ADD;
                        alu_en_reg      <= 1'b0;
                    end else if (lane_last) begin
                        state_reg  <= ST_DONE;
                        alu_en_reg <= 1'b0;
                        done_reg   <= 1'b1;
                        branch_reg <= (op_reg == OP_BEQ) && eq_reg && alu_zero;
                    end else begin
                        state_reg <= ST_EXEC;
                        lane_reg  <= lane_reg + LANE_W'(1);
                    end
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    lane_reg        <= '0;
                    alu_control_reg <= ALU_ADD;
                    alu_en_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign issue_ready  = (state_reg == ST_IDLE);
    assign stall        = (state_reg != ST_IDLE);
    assign alu_control  = alu_control_reg;
    assign alu_en       = alu_en_reg;
    assign lane_idx     = lane_reg;
    assign lane_we      = lane_we_reg;
    assign done         = done_reg;
    assign branch_taken = branch_reg;
    assign illegal      = illegal_reg;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed bench for vec_alu_sequencer: a per-instruction timeline model checked
// every cycle, plus hand-computed cycle numbers for the key scenarios.
module tb_vec_alu_sequencer;

    localparam int LANES   = 4;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;
    localparam int LW      = $clog2(LANES);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue_valid = 1'b0;
    logic [3:0]    opcode = 4'b0000;
    logic          issue_ready;
    logic          flush = 1'b0;
    logic [1:0]    alu_control;
    logic          alu_en;
    logic [LW-1:0] lane_idx;
    logic          alu_zero;
    logic          lane_we;
    logic          stall;
    logic          done;
    logic          branch_taken;
    logic          illegal;

    logic [LANES-1:0] zero_pat = '1;

    vec_alu_sequencer #(
        .LANES  (LANES),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .opcode      (opcode),
        .issue_ready (issue_ready),
        .flush       (flush),
        .alu_control (alu_control),
        .alu_en      (alu_en),
        .lane_idx    (lane_idx),
        .alu_zero    (alu_zero),
        .lane_we     (lane_we),
        .stall       (stall),
        .done        (done),
        .branch_taken(branch_taken),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Scalar ALU stand-in: zero flag per lane comes from a bench-chosen pattern.
    assign alu_zero = zero_pat[lane_idx];

    typedef struct packed {
        logic          en;
        logic          we;
        logic [LW-1:0] lane;
        logic [1:0]    ctl;
        logic          dn;
        logic          bt;
        logic          ill;
        logic          busy;
    } rec_t;

    rec_t cur = '0;
    rec_t exp_q[$];
    int   acc_cyc = 0;

    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'b0000: return MUL_LAT;
            4'b0001: return DIV_LAT;
            default: return 1;
        endcase
    endfunction

    function automatic logic [1:0] code_of(input logic [3:0] op);
        case (op)
            4'b0000: return 2'b01;
            4'b0001: return 2'b10;
            4'b1001: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic legal_of(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0100) || (op == 4'b1001);
    endfunction

    // Whole-instruction timeline: lat execute cycles + one write-back per lane, then done.
    task automatic build(input logic [3:0] op);
        rec_t r;
        exp_q.delete();
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < lat_of(op); k++) begin
                r = '0; r.en = 1'b1; r.lane = LW'(l); r.ctl = code_of(op); r.busy = 1'b1;
                exp_q.push_back(r);
            end
            r = '0; r.en = 1'b1; r.we = (op != 4'b1001); r.lane = LW'(l);
            r.ctl = code_of(op); r.busy = 1'b1;
            exp_q.push_back(r);
        end
        r = '0; r.dn = 1'b1; r.bt = (op == 4'b1001) && (&zero_pat);
        r.lane = LW'(LANES - 1); r.ctl = code_of(op); r.busy = 1'b1;
        exp_q.push_back(r);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            cur <= '0;
        end else begin
            acc_cyc <= acc_cyc + 1;
            if (cur.busy) begin
                if (flush || exp_q.size() == 0) begin
                    exp_q.delete();
                    cur <= '0;
                end else begin
                    cur <= exp_q.pop_front();
                end
            end else if (issue_valid && !flush) begin
                acc_cyc <= 1;
                if (legal_of(opcode)) begin
                    build(opcode);
                    cur <= exp_q.pop_front();
                end else begin
                    cur <= '{ill: 1'b1, default: '0};
                end
            end else begin
                cur <= '0;
            end
        end
    end

    int compared   = 0;
    int mismatched = 0;

    int lwe_cyc[$];
    int done_cyc, done_cnt, bt_at_done, ill_cnt, ill_cyc, en0_first, en0_last, ready_cyc, stall_any;
    int tot_ill = 0;
    int tot_done = 0;

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock cycle: compare on the falling edge, then return just after the rising edge.
    task automatic tick();
        logic [11:0] act_v, exp_v;
        @(negedge clk);
        act_v = {alu_en, lane_we, lane_idx, alu_control, done, branch_taken, illegal, stall, issue_ready};
        exp_v = {cur, ~cur.busy};
        compared++;
        if (act_v !== exp_v) begin
            mismatched++;
            $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act_v, exp_v);
        end
        if (acc_cyc == 1) begin
            lwe_cyc.delete();
            done_cyc = 0; done_cnt = 0; bt_at_done = 0; ill_cnt = 0; ill_cyc = 0;
            en0_first = 0; en0_last = 0; ready_cyc = 0; stall_any = 0;
        end
        if (lane_we) lwe_cyc.push_back(acc_cyc);
        if (done) begin done_cnt++; tot_done++; done_cyc = acc_cyc; bt_at_done = int'(branch_taken); end
        if (illegal) begin ill_cnt++; tot_ill++; ill_cyc = acc_cyc; end
        if (alu_en && lane_idx == '0) begin
            if (en0_first == 0) en0_first = acc_cyc;
            en0_last = acc_cyc;
        end
        if (done_cnt > 0 && issue_ready && ready_cyc == 0) ready_cyc = acc_cyc;
        if (stall) stall_any = 1;
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [3:0] op);
        issue_valid = 1'b1;
        opcode = op;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    int snap_ill, snap_done;

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_issue_ready", int'(issue_ready), 1);
        chk("reset_outputs", int'({alu_en, lane_we, lane_idx, alu_control, done, branch_taken, illegal, stall}), 0);
        run(2);
        rst = 1'b0;
        run(2);

        // ADD: lane_we 2,4,6,8; done 9; ready 10
        issue(4'b0100);
        run(12);
        chk("add_we_count", lwe_cyc.size(), 4);
        for (int i = 0; i < lwe_cyc.size() && i < 4; i++) chk("add_we_cycle", lwe_cyc[i], 2 * i + 2);
        chk("add_done_cycle", done_cyc, 9);
        chk("add_ready_cycle", ready_cyc, 10);

        // DIV: lane 0 alu_en 1..9, first lane_we 9, done 37
        issue(4'b0001);
        run(40);
        chk("div_en0_first", en0_first, 1);
        chk("div_en0_last", en0_last, 9);
        chk("div_first_we", (lwe_cyc.size() > 0) ? lwe_cyc[0] : -1, 9);
        chk("div_done_cycle", done_cyc, 37);

        // MUL: done at 4*(2+1)+1 = 13
        issue(4'b0000);
        run(15);
        chk("mul_done_cycle", done_cyc, 13);

        // BEQ all lanes equal
        zero_pat = 4'b1111;
        issue(4'b1001);
        run(12);
        chk("beq_eq_taken", bt_at_done, 1);
        chk("beq_eq_done", done_cnt, 1);
        chk("beq_eq_no_we", lwe_cyc.size(), 0);

        // BEQ lane 2 differs
        zero_pat = 4'b1011;
        issue(4'b1001);
        run(12);
        chk("beq_ne_taken", bt_at_done, 0);
        chk("beq_ne_done_cycle", done_cyc, 9);
        chk("beq_ne_no_we", lwe_cyc.size(), 0);
        zero_pat = 4'b1111;

        // Unsupported opcode
        issue(4'b0010);
        run(4);
        chk("ill_count", ill_cnt, 1);
        chk("ill_cycle", ill_cyc, 1);
        chk("ill_no_done", done_cnt, 0);
        chk("ill_no_stall", stall_any, 0);

        // flush with issue_valid in IDLE blocks both acceptance and illegal
        snap_ill = tot_ill;
        snap_done = tot_done;
        flush = 1'b1;
        issue(4'b0010);
        issue(4'b0100);
        flush = 1'b0;
        run(3);
        chk("idle_flush_no_illegal", tot_ill - snap_ill, 0);
        chk("idle_flush_no_accept", tot_done - snap_done, 0);
        chk("idle_flush_ready", int'(issue_ready), 1);

        // MUL flushed in lane 1 EXEC (cycle 4)
        issue(4'b0000);
        run(3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        run(6);
        chk("flush_we_count", lwe_cyc.size(), 1);
        chk("flush_no_done", done_cnt, 0);
        issue(4'b0100);
        run(12);
        chk("post_flush_add_done", done_cyc, 9);
        chk("post_flush_add_we", lwe_cyc.size(), 4);

        // Asynchronous reset mid-DIV
        issue(4'b0001);
        run(10);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_ready", int'(issue_ready), 1);
        chk("async_rst_outputs", int'({alu_en, lane_we, lane_idx, alu_control, done, branch_taken, illegal, stall}), 0);
        tick();
        tick();
        rst = 1'b0;
        run(40);
        chk("async_rst_no_done", done_cnt, 0);
        chk("async_rst_ready_after", int'(issue_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
